vec_issue_queue: RTL and testbench

- Buffers vector instructions, with their rs1/rs2 scalar operands, arriving from the scalar processor.
- Presents exactly one instruction at a time to the vector processor datapath and holds it stable until the datapath's inst_done fires.
- Sits directly upstream of the datapath, which decodes instruction/rs1_data/rs2_data combinationally and needs them held for the whole execution.
- Also detects illegal (non-vector) instructions and stuck instructions (timeout).

---
 rtl/vec_issue_queue.sv | 133 +++++++++++++
 tb/tb_vec_issue_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_queue.sv
// Issue queue between the scalar core and the vector datapath. It buffers
// {inst, rs1, rs2}, issues one at a time, and flags non-vector and stuck instructions.
module vec_issue_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_valid,
  input  logic [XLEN-1:0]        inst_in,
  input  logic [XLEN-1:0]        rs1_in,
  input  logic [XLEN-1:0]        rs2_in,
  output logic                   inst_ready,
  input  logic                   flush,
  output logic                   issue_valid,
  output logic [XLEN-1:0]        issue_inst,
  output logic [XLEN-1:0]        issue_rs1,
  output logic [XLEN-1:0]        issue_rs2,
  input  logic                   is_vec,
  input  logic                   inst_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   illegal_inst,
  output logic                   timeout_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;

  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_rs1  [DEPTH];
  logic [XLEN-1:0] mem_rs2  [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   cyc_cnt;
  logic            first_cycle;
  logic            push, load, illegal_d, timeout_d;

  // Handshake: a push happens on inst_valid && inst_ready; ready uses the
  // registered count only, so a same-cycle pop never makes room for a push.
  assign inst_ready  = (count < FULL) && !flush;
  assign push        = inst_valid && inst_ready;
  assign issue_valid = (state_q == EXEC);
  assign busy        = issue_valid || (count != '0);
  assign queue_count = count;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && count != '0) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (first_cycle && !is_vec) begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end else if (inst_done) begin
          if (count != '0) load = 1'b1;
          else             state_d = IDLE;
        end else if (cyc_cnt == LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= inst_in;
      mem_rs1[wr_ptr]  <= rs1_in;
      mem_rs2[wr_ptr]  <= rs2_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(load);
    end
  end

  // The issue registers only change on a load, so the datapath sees them frozen in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      issue_inst   <= '0;
      issue_rs1    <= '0;
      issue_rs2    <= '0;
      cyc_cnt      <= '0;
      first_cycle  <= 1'b0;
      illegal_inst <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_inst <= illegal_d;
      timeout_err  <= timeout_d;
      first_cycle  <= load;
      if (load) begin
        issue_inst <= mem_inst[rd_ptr];
        issue_rs1  <= mem_rs1[rd_ptr];
        issue_rs2  <= mem_rs2[rd_ptr];
        cyc_cnt    <= '0;
      end else if (state_q == EXEC && cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed bench for vec_issue_queue: a queue-based model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_vec_issue_queue;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_valid, flush, is_vec, inst_done;
  logic [XLEN-1:0] inst_in, rs1_in, rs2_in;
  logic            inst_ready, issue_valid, busy, illegal_inst, timeout_err;
  logic [XLEN-1:0] issue_inst, issue_rs1, issue_rs2;
  logic [2:0]      queue_count;

  int n_vec = 0;
  int n_bad = 0;

  vec_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_in(inst_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .inst_ready(inst_ready), .flush(flush),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .is_vec(is_vec), .inst_done(inst_done), .busy(busy),
    .queue_count(queue_count), .illegal_inst(illegal_inst), .timeout_err(timeout_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the queue holds {inst,rs1,rs2}; m_age counts EXEC cycles starting at 1.
  logic [3*XLEN-1:0] exp_q[$];
  logic [3*XLEN-1:0] m_cur;
  bit                m_exec, m_ill, m_to, m_take, m_push;
  int                m_age, m_sz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_cur  = '0;
      m_exec = 0;
      m_age  = 0;
      m_ill  = 0;
      m_to   = 0;
    end else begin
      m_sz   = exp_q.size();
      m_take = 0;
      m_ill  = 0;
      m_to   = 0;
      m_push = inst_valid && !flush && (m_sz < DEPTH);
      if (flush) begin
        exp_q.delete();
        m_exec = 0;
      end else if (!m_exec) m_take = (m_sz > 0);
      else if (m_age == 1 && !is_vec) begin m_ill = 1; m_exec = 0; end
      else if (inst_done) begin
        if (m_sz > 0) m_take = 1;
        else m_exec = 0;
      end else if (m_age == TIMEOUT) begin m_to = 1; m_exec = 0; end
      else m_age++;
      if (m_take) begin
        m_cur  = exp_q.pop_front();
        m_exec = 1;
        m_age  = 1;
      end
      if (m_push) exp_q.push_back({inst_in, rs1_in, rs2_in});
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("issue_valid", 32'(issue_valid), 32'(m_exec));
      check("issue_inst", issue_inst, m_cur[3*XLEN-1:2*XLEN]);
      check("issue_rs1", issue_rs1, m_cur[2*XLEN-1:XLEN]);
      check("issue_rs2", issue_rs2, m_cur[XLEN-1:0]);
      check("queue_count", 32'(queue_count), 32'(exp_q.size()));
      check("busy", 32'(busy), 32'(m_exec || exp_q.size() > 0));
      check("illegal_inst", 32'(illegal_inst), 32'(m_ill));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
      check("inst_ready", 32'(inst_ready), 32'(exp_q.size() < DEPTH && !flush));
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    inst_valid = 1'b1;
    inst_in    = i;
    rs1_in     = a;
    rs2_in     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v[4];
    reset = 1'b0; inst_valid = 1'b0; flush = 1'b0; is_vec = 1'b1; inst_done = 1'b0;
    inst_in = '0; rs1_in = '0; rs2_in = '0;
    #2;
    check("rst_issue_valid", 32'(issue_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_queue_count", 32'(queue_count), 0);
    check("rst_issue_inst", issue_inst, 0);
    cyc();
    reset = 1'b1;
    #1 check("ready_after_reset", 32'(inst_ready), 1);

    // single instruction, done on 5th EXEC cycle
    offer(32'h0000_5057, 32'h10, 32'h20);
    cyc();
    inst_valid = 1'b0;
    check("t1_count_after_push", 32'(queue_count), 1);
    check("t1_not_yet_valid", 32'(issue_valid), 0);
    cyc();
    check("t1_issue_valid", 32'(issue_valid), 1);
    check("t1_issue_inst", issue_inst, 32'h0000_5057);
    check("t1_issue_rs1", issue_rs1, 32'h10);
    check("t1_issue_rs2", issue_rs2, 32'h20);
    repeat (4) cyc();
    check("t1_held_inst", issue_inst, 32'h0000_5057);
    inst_done = 1'b1;
    cyc();
    inst_done = 1'b0;
    check("t1_done_valid", 32'(issue_valid), 0);
    check("t1_done_busy", 32'(busy), 0);

    // fill to full behind an executing holder, then drain back-to-back
    offer(32'h0000_A057, 32'h1, 32'h2);
    cyc();
    inst_valid = 1'b0;
    cyc();
    v[0] = 32'h0000_B057; v[1] = 32'h0000_C057; v[2] = 32'h0000_D057; v[3] = 32'h0000_E057;
    for (int i = 0; i < 4; i++) begin
      offer(v[i], 32'(i), 32'(i + 100));
      cyc();
      check("t2_count_walk", 32'(queue_count), 32'(i + 1));
    end
    offer(32'h0000_F057, 32'h0, 32'h0);
    #1 check("t2_full_not_ready", 32'(inst_ready), 0);
    cyc();
    inst_valid = 1'b0;
    check("t2_count_full", 32'(queue_count), 4);
    check("t2_holder", issue_inst, 32'h0000_A057);
    inst_done = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("t2_order_inst", issue_inst, v[i]);
      check("t2_order_rs2", issue_rs2, 32'(i + 100));
      check("t2_no_bubble", 32'(issue_valid), 1);
      check("t2_count_drain", 32'(queue_count), 32'(3 - i));
      cyc();
    end
    inst_done = 1'b0;
    check("t2_idle", 32'(issue_valid), 0);

    // illegal instruction dropped, next one issues a cycle later
    offer(32'h0000_0033, 32'h5, 32'h6);
    cyc();
    offer(32'h0000_2057, 32'h7, 32'h8);
    cyc();
    inst_valid = 1'b0;
    is_vec = 1'b0;
    cyc();
    is_vec = 1'b1;
    check("t3_illegal_pulse", 32'(illegal_inst), 1);
    check("t3_dropped", 32'(issue_valid), 0);
    check("t3_count", 32'(queue_count), 1);
    cyc();
    check("t3_illegal_once", 32'(illegal_inst), 0);
    check("t3_next_inst", issue_inst, 32'h0000_2057);
    check("t3_next_valid", 32'(issue_valid), 1);
    inst_done = 1'b1;
    cyc();
    inst_done = 1'b0;

    // timeout after 8 EXEC cycles, queue untouched by the abort
    offer(32'h0000_3057, 32'h9, 32'ha);
    cyc();
    inst_valid = 1'b0;
    cyc();
    offer(32'h0000_4057, 32'hb, 32'hc);
    cyc();
    inst_valid = 1'b0;
    repeat (6) cyc();
    check("t4_no_early_timeout", 32'(timeout_err), 0);
    check("t4_still_exec", 32'(issue_valid), 1);
    cyc();
    check("t4_timeout_pulse", 32'(timeout_err), 1);
    check("t4_aborted", 32'(issue_valid), 0);
    check("t4_count_kept", 32'(queue_count), 1);
    cyc();
    check("t4_timeout_once", 32'(timeout_err), 0);
    check("t4_next_inst", issue_inst, 32'h0000_4057);

    // flush with 3 queued plus 1 in EXEC
    for (int i = 0; i < 3; i++) begin
      offer(32'h0000_6057 + 32'(i), 32'(i), 32'(i));
      cyc();
    end
    check("t5_count_before", 32'(queue_count), 3);
    flush = 1'b1;
    offer(32'h0000_7057, 32'h0, 32'h0);
    #1 check("t5_flush_not_ready", 32'(inst_ready), 0);
    cyc();
    flush = 1'b0;
    inst_valid = 1'b0;
    #1;
    check("t5_count_zero", 32'(queue_count), 0);
    check("t5_valid_zero", 32'(issue_valid), 0);
    check("t5_ready_after", 32'(inst_ready), 1);
    check("t5_no_illegal", 32'(illegal_inst), 0);
    check("t5_no_timeout", 32'(timeout_err), 0);
    cyc();
    check("t5_stays_idle", 32'(issue_valid), 0);

    // asynchronous reset mid-EXEC with 2 queued
    offer(32'h0000_8057, 32'h1, 32'h1);
    cyc();
    inst_valid = 1'b0;
    cyc();
    offer(32'h0000_9057, 32'h2, 32'h2);
    cyc();
    offer(32'h0000_9157, 32'h3, 32'h3);
    cyc();
    inst_valid = 1'b0;
    check("t6_count_before", 32'(queue_count), 2);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(issue_valid), 0);
    check("t6_rst_inst", issue_inst, 0);
    check("t6_rst_rs1", issue_rs1, 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_count", 32'(queue_count), 0);
    check("t6_rst_illegal", 32'(illegal_inst), 0);
    check("t6_rst_timeout", 32'(timeout_err), 0);
    cyc();
    reset = 1'b1;
    #1 check("t6_ready", 32'(inst_ready), 1);
    offer(32'h0000_5157, 32'h44, 32'h55);
    cyc();
    inst_valid = 1'b0;
    cyc();
    check("t6_fresh_valid", 32'(issue_valid), 1);
    check("t6_fresh_inst", issue_inst, 32'h0000_5157);
    check("t6_fresh_rs1", issue_rs1, 32'h44);
    inst_done = 1'b1;
    cyc();
    inst_done = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
